uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_pkg.sv | 26 ++
 rtl/uart_tx_fifo_if.sv | 12 +
 rtl/uart_tx_fifo_byte_fifo.sv | 57 +++++
 rtl/uart_tx_fifo.sv | 156 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, frame sizes, defaults.
// Defining UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
package uart_tx_fifo_pkg;

   localparam int DEF_CLK_DIV    = 16;
   localparam int DEF_DEPTH_LOG2 = 4;
   localparam int DATA_BITS      = 8;
   localparam int IDX_W          = 3;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte-write and status bundle between a host and the UART transmitter.
interface uart_tx_fifo_if;
   logic [7:0] DATA;
   logic       WE;
   logic       FULL;
   logic       BUSY;
   logic       OVERFLOW;
   logic       TXD;

   modport master (output DATA, output WE, input FULL, input BUSY, input OVERFLOW, input TXD);
   modport slave  (input DATA, input WE, output FULL, output BUSY, output OVERFLOW, output TXD);
endinterface

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Byte FIFO with synchronous write/pop, registered count, and full/empty flags.
module byte_fifo #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [7:0]          wr_data,
   input  logic                pop,
   output logic [7:0]          head,
   output logic                full,
   output logic                empty,
   output logic [DEPTH_LOG2:0] count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic                  wr_acc;
   logic                  pop_acc;

   // full is the pre-edge view, so a pop on the same edge cannot make room for a write
   assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
   assign empty   = (count == '0);
   assign wr_acc  = wr_en && !full;
   assign pop_acc = pop && !empty;
   assign head    = mem[rptr];

   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_acc) begin
            wptr <= wptr + 1'b1;
         end
         if (pop_acc) begin
            rptr <= rptr + 1'b1;
         end
         case ({wr_acc, pop_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a byte FIFO: 8N1 frames, LSB first, CLK_DIV clocks per bit.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (0)
// DATA   | data bit idx, LSB first
// PARITY | even parity over the byte (UART_TX_PARITY_EN only)
// STOP   | stop bit (1); pops straight into START if more bytes are queued
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int CLK_DIV    = DEF_CLK_DIV,
   parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
   input  logic          CLK,
   input  logic          RESET,
   uart_tx_fifo_if.slave bus
);

   localparam int TW = $clog2(CLK_DIV);

   state_t                state, state_n;
   logic [TW-1:0]         timer, timer_n;
   logic [IDX_W-1:0]      idx, idx_n;
   logic [DATA_BITS-1:0]  shreg, shreg_n;
   logic                  txd_q, txd_n;
   logic                  ovf_q;
   logic                  pop;
   logic                  last;
   logic [7:0]            head;
   logic                  full;
   logic                  empty;
   logic [DEPTH_LOG2:0]   count;

   byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
      .clk     (CLK),
      .rst     (RESET),
      .wr_en   (bus.WE),
      .wr_data (bus.DATA),
      .pop     (pop),
      .head    (head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   assign last         = (timer == TW'(CLK_DIV - 1));
   assign bus.TXD      = txd_q;
   assign bus.FULL     = full;
   assign bus.OVERFLOW = ovf_q;
   assign bus.BUSY     = (state != ST_IDLE) || (count != '0);

   always_comb begin
      state_n = state;
      timer_n = timer;
      idx_n   = idx;
      shreg_n = shreg;
      pop     = 1'b0;
      case (state)
         ST_IDLE: begin
            timer_n = '0;
            if (!empty) begin
               pop     = 1'b1;
               shreg_n = head;
               state_n = ST_START;
            end
         end
         ST_START: begin
            if (last) begin
               timer_n = '0;
               idx_n   = '0;
               state_n = ST_DATA;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         ST_DATA: begin
            if (last) begin
               timer_n = '0;
               if (idx == IDX_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_n = ST_PARITY;
`else
                  state_n = ST_STOP;
`endif
               end else begin
                  idx_n = idx + 1'b1;
               end
            end else begin
               timer_n = timer + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (last) begin
               timer_n = '0;
               state_n = ST_STOP;
            end else begin
               timer_n = timer + 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (last) begin
               timer_n = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  shreg_n = head;
                  state_n = ST_START;
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         default: begin
            timer_n = '0;
            state_n = ST_IDLE;
         end
      endcase

      // line value is decided from the upcoming state so TXD comes straight off a flop
      txd_n = 1'b1;
      case (state_n)
         ST_START:  txd_n = 1'b0;
         ST_DATA:   txd_n = shreg_n[idx_n];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: txd_n = ^shreg_n;
`endif
         default:   txd_n = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= ST_IDLE;
         timer <= '0;
         idx   <= '0;
         shreg <= '0;
         txd_q <= 1'b1;
         ovf_q <= 1'b0;
      end else begin
         state <= state_n;
         timer <= timer_n;
         idx   <= idx_n;
         shreg <= shreg_n;
         txd_q <= txd_n;
         if (bus.WE && full) begin
            ovf_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at CLK_DIV=4, DEPTH_LOG2=2 (4-byte FIFO).
module tb_uart_tx_fifo;
   import uart_tx_fifo_pkg::*;

   localparam int CD = 4;

   logic CLK;
   logic RESET;
   int   vectors;
   int   miscompares;
   int   edge_cnt;

   uart_tx_fifo_if bus ();

   uart_tx_fifo #(.CLK_DIV(CD), .DEPTH_LOG2(2)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
      edge_cnt++;
   endtask

   task automatic chk(input logic obs, input logic exp, input string tag);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, obs, exp, edge_cnt);
      end
   endtask

   // Samples a whole frame starting at the current cycle, ticking once per sample.
   task automatic expect_frame(input logic [7:0] b, input string tag);
      logic bits [FRAME_BITS];
      bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) bits[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
      bits[9] = ^b;
`endif
      bits[FRAME_BITS-1] = 1'b1;
      for (int i = 0; i < FRAME_BITS; i++) begin
         for (int j = 0; j < CD; j++) begin
            chk(bus.TXD, bits[i], $sformatf("%s_bit%0d_c%0d", tag, i, j));
            if (i == FRAME_BITS - 1 && j == CD - 1) chk(bus.BUSY, 1'b1, {tag, "_busy_last"});
            tick();
            bus.WE = 1'b0;
         end
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      edge_cnt    = 0;
      RESET       = 1'b1;
      bus.WE      = 1'b0;
      bus.DATA    = 8'h00;

      // reset state
      tick(); tick(); tick();
      RESET = 1'b0;
      chk(bus.TXD,      1'b1, "rst_txd");
      chk(bus.BUSY,     1'b0, "rst_busy");
      chk(bus.FULL,     1'b0, "rst_full");
      chk(bus.OVERFLOW, 1'b0, "rst_ovf");

      // single 0x55 written at edge 10: start bit over edges 11-14, stop from 47
      while (edge_cnt < 9) tick();
      bus.WE = 1'b1; bus.DATA = 8'h55;
      tick();
      bus.WE = 1'b0;
      chk(bus.TXD,  1'b1, "w55_txd_at_write");
      chk(bus.BUSY, 1'b1, "w55_busy_at_write");
      tick();
      expect_frame(8'h55, "f55");
      chk(bus.TXD,  1'b1, "f55_idle_txd");
      chk(bus.BUSY, 1'b0, "f55_idle_busy");

      // back-to-back 0x41, 0x42: no idle gap, BUSY drops right after the second stop bit
      tick(); tick();
      bus.WE = 1'b1; bus.DATA = 8'h41;
      tick();
      bus.DATA = 8'h42;
      tick();
      bus.WE = 1'b0;
      expect_frame(8'h41, "f41");
      expect_frame(8'h42, "f42");
      chk(bus.BUSY, 1'b0, "f42_busy_after");
      chk(bus.TXD,  1'b1, "f42_txd_after");

      // six writes into a 4-deep FIFO while the line is busy
      tick();
      for (int i = 0; i < 6; i++) begin
         bus.WE = 1'b1; bus.DATA = 8'h10 + 8'(i);
         tick();
         if (i == 3) chk(bus.FULL, 1'b0, "ovf_full_after4");
         if (i == 4) begin
            chk(bus.FULL,     1'b1, "ovf_full_after5");
            chk(bus.OVERFLOW, 1'b0, "ovf_flag_after5");
         end
      end
      bus.WE = 1'b0;
      chk(bus.FULL,     1'b1, "ovf_full_after6");
      chk(bus.OVERFLOW, 1'b1, "ovf_flag_after6");

      // mid-frame reset with WE held high: everything clears and the write is ignored
      RESET = 1'b1; bus.WE = 1'b1; bus.DATA = 8'hAA;
      tick();
      RESET = 1'b0; bus.WE = 1'b0;
      chk(bus.TXD,      1'b1, "rst2_txd");
      chk(bus.BUSY,     1'b0, "rst2_busy");
      chk(bus.FULL,     1'b0, "rst2_full");
      chk(bus.OVERFLOW, 1'b0, "rst2_ovf");
      tick();
      chk(bus.BUSY, 1'b0, "rst2_we_ignored");
      chk(bus.TXD,  1'b1, "rst2_txd_idle");

      // FULL with WE on the same edge as a pop: byte dropped, room for exactly one more
      for (int i = 0; i < 5; i++) begin
         bus.WE = 1'b1; bus.DATA = 8'h20 + 8'(i);
         tick();
      end
      bus.WE = 1'b0;
      chk(bus.FULL,     1'b1, "pop_full_before");
      chk(bus.OVERFLOW, 1'b0, "pop_ovf_before");
      for (int i = 0; i < 36; i++) tick();
      chk(bus.FULL, 1'b1, "pop_full_prepop");
      bus.WE = 1'b1; bus.DATA = 8'hEE;
      tick();
      chk(bus.FULL,     1'b0, "pop_full_after");
      chk(bus.OVERFLOW, 1'b1, "pop_ovf_after");
      chk(bus.TXD,      1'b0, "pop_next_start");
      bus.WE = 1'b1; bus.DATA = 8'h30;
      expect_frame(8'h21, "f21");
      expect_frame(8'h22, "f22");
      expect_frame(8'h23, "f23");
      expect_frame(8'h24, "f24");
      expect_frame(8'h30, "f30");
      chk(bus.BUSY, 1'b0, "pop_drained_busy");

      // reset pulse during data bit 3 of 0x00
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      bus.WE = 1'b1; bus.DATA = 8'h00;
      tick();
      bus.WE = 1'b0;
      tick();
      for (int i = 0; i < 17; i++) tick();
      chk(bus.TXD,  1'b0, "abort_in_bit3");
      chk(bus.BUSY, 1'b1, "abort_busy_before");
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      chk(bus.TXD,  1'b1, "abort_txd");
      chk(bus.BUSY, 1'b0, "abort_busy");
      for (int i = 0; i < 50; i++) begin
         tick();
         chk(bus.TXD, 1'b1, $sformatf("abort_quiet_%0d", i));
      end

      // 0x07: odd bit count, parity bit 1 when enabled
      bus.WE = 1'b1; bus.DATA = 8'h07;
      tick();
      bus.WE = 1'b0;
      tick();
      expect_frame(8'h07, "f07");
      chk(bus.TXD,  1'b1, "f07_idle_txd");
      chk(bus.BUSY, 1'b0, "f07_idle_busy");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
